mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 45 ++++
 rtl/mc_opcode_decoder.sv | 24 ++
 rtl/mc_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM.
// State, opcode, opcode-class and ALUOp constants live here.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_ILL
    } op_class_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Packs {alu_op, alu_src} for the execute step of each class.
    function automatic logic [2:0] alu_ctl(input op_class_t c);
        logic [2:0] r;
        case (c)
            CL_R:    r = {ALU_FUNCT, 1'b0};
            CL_I:    r = {ALU_FUNCT, 1'b1};
            CL_BEQ:  r = {ALU_SUB, 1'b0};
            default: r = {ALU_ADD, 1'b1};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_opcode_decoder.sv
// Combinational opcode classifier used while the FSM sits in DECODE.
// Anything outside the five supported opcodes is flagged illegal.
module opcode_decoder
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       legal
);

    always_comb begin
        op_class = CL_ILL;
        legal    = 1'b1;
        unique case (1'b1)
            (opcode == OP_R):   op_class = CL_R;
            (opcode == OP_I):   op_class = CL_I;
            (opcode == OP_LW):  op_class = CL_LW;
            (opcode == OP_SW):  op_class = CL_SW;
            (opcode == OP_BEQ): op_class = CL_BEQ;
            default:            legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// sticky illegal-opcode trap and retired-instruction counter.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t      state_q;
    state_t      state_d;
    op_class_t   cls_q;
    op_class_t   dec_cls;
    logic        dec_legal;
    logic        illegal_q;
    logic [31:0] instret_q;
    logic        retire;

    logic pc_w;
    logic pc_src_c;
    logic ir_w;
    logic mem_req_c;
    logic mem_we_c;
    logic reg_w;

    opcode_decoder u_dec (
        .opcode   (opcode),
        .op_class (dec_cls),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cls_q     <= CL_R;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q <= dec_cls;
                if (!dec_legal) illegal_q <= 1'b1;
            end
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_w       = 1'b0;
        pc_src_c   = 1'b0;
        ir_w       = 1'b0;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        mem_sel    = 1'b0;
        reg_w      = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = dec_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                {alu_op, alu_src} = alu_ctl(cls_q);
                case (cls_q)
                    CL_R, CL_I:   state_d = ST_WB;
                    CL_LW, CL_SW: state_d = ST_MEM;
                    default: begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                        if (zero) begin
                            pc_w     = 1'b1;
                            pc_src_c = 1'b1;
                        end
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_c = 1'b1;
                mem_sel   = 1'b1;
                mem_we_c  = (cls_q == CL_SW);
                alu_op    = ALU_ADD;
                alu_src   = 1'b1;
                if (mem_ready) begin
                    if (cls_q == CL_SW) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_w             = 1'b1;
                mem_to_reg        = (cls_q == CL_LW);
                {alu_op, alu_src} = alu_ctl(cls_q);
                state_d           = ST_FETCH;
                retire            = 1'b1;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Strobes are held low for the whole reset so an abandoned
    // instruction can neither write nor redirect the PC.
    assign pc_write  = pc_w & rst_n;
    assign pc_src    = pc_src_c & rst_n;
    assign ir_write  = ir_w & rst_n;
    assign mem_req   = mem_req_c & rst_n;
    assign mem_we    = mem_we_c & rst_n;
    assign reg_write = reg_w & rst_n;

    assign state   = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule
